// File: rtl/cache_arbiter_pkg.sv
// Shared types for the two-port cache-to-memory arbiter.
package cache_arbiter_types;

    typedef enum logic [1:0] {IDLE, SERVE, GAP} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} arb_port_t;
    typedef enum logic {OP_READ, OP_WRITE} arb_op_t;

    // The port that round-robin favours after p has been served.
    function automatic arb_port_t other_port(arb_port_t p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Cache-side request/response buses plus the physical-memory port.
// slave is the arbiter's view, master is the surrounding system's view.
interface cache_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_resp, pmem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address,
               pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_resp, pmem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address,
               pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: picks the next port in IDLE, tracks last grant for
// round-robin and sequences IDLE -> SERVE -> GAP.
module arbiter_control
    import cache_arbiter_types::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  logic       d_write_i,
    input  logic       pmem_resp_i,
    output arb_state_t state_o,
    output logic       load_o,
    output arb_port_t  grant_port_o,
    output arb_op_t    grant_op_o
);
    arb_state_t state_q;
    arb_port_t  last_grant_q;

    assign state_o = state_q;

    // Grant selection; only consumed when load_o is high.
    always_comb begin
        grant_port_o = PORT_I;
        if (i_req_i && d_req_i) begin
            grant_port_o = other_port(last_grant_q);
        end else if (d_req_i) begin
            grant_port_o = PORT_D;
        end
        // Write wins if a D read and write are raised together.
        grant_op_o = (grant_port_o == PORT_D && d_write_i) ? OP_WRITE : OP_READ;
        load_o     = (state_q == IDLE) && (i_req_i || d_req_i);
    end

    // State and round-robin history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_I;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_o) begin
                        state_q      <= SERVE;
                        last_grant_q <= grant_port_o;
                    end
                end
                SERVE: begin
                    if (pmem_resp_i) begin
                        state_q <= GAP;
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/cache_arbiter.sv
// Multiplexes I-cache and D-cache line transfers onto one memory port,
// one transaction at a time, with the request captured at grant.
module cache_arbiter
    import cache_arbiter_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input logic            clk,
    input logic            rst_n,
    cache_arbiter_if.slave bus
);
    arb_state_t        state;
    logic              load;
    arb_port_t         grant_port;
    arb_op_t           grant_op;

    arb_port_t         grant_q;
    arb_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [LINE_W-1:0] wdata_q;
    logic              serving;

    arbiter_control u_control (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .i_req_i      (bus.i_read),
        .d_req_i      (bus.d_read | bus.d_write),
        .d_write_i    (bus.d_write),
        .pmem_resp_i  (bus.pmem_resp),
        .state_o      (state),
        .load_o       (load),
        .grant_port_o (grant_port),
        .grant_op_o   (grant_op)
    );

    // Address of the port about to be granted.
    always_comb begin
        addr_d = (grant_port == PORT_D) ? bus.d_address : bus.i_address;
    end

    // Request capture; later input changes are ignored until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= PORT_I;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load) begin
            grant_q <= grant_port;
            op_q    <= grant_op;
            addr_q  <= addr_d;
            wdata_q <= bus.d_wdata;
        end
    end

    // Memory strobes from registered state; response routed to the granted port.
    always_comb begin
        serving          = (state == SERVE);
        bus.pmem_read    = serving && (op_q == OP_READ);
        bus.pmem_write   = serving && (op_q == OP_WRITE);
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = wdata_q;
        bus.i_resp       = serving && bus.pmem_resp && (grant_q == PORT_I);
        bus.d_resp       = serving && bus.pmem_resp && (grant_q == PORT_D);
        bus.i_rdata      = bus.pmem_rdata;
        bus.d_rdata      = bus.pmem_rdata;
    end

    a_d_read_write_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.d_read && bus.d_write)
    );
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the caches and memory.
module tb_cache_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Physical memory model.
    logic [LW-1:0] mem [logic [AW-1:0]];
    int lat       = 0;
    int fixed_lat = 0;
    bit rand_lat  = 0;
    int wait_cnt  = 0;

    function automatic logic [LW-1:0] init_line(logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0F0F}};
    endfunction

    function automatic logic [LW-1:0] mem_rd(logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return init_line(a);
    endfunction

    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (wait_cnt >= lat) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) mem[bus.pmem_address] = bus.pmem_wdata;
                    else bus.pmem_rdata = mem_rd(bus.pmem_address);
                    wait_cnt = 0;
                    lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lat(int n);
        fixed_lat = n;
        lat       = n;
        rand_lat  = 0;
    endtask

    task automatic do_reset();
        bus.i_read  = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks += 6;
        if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read: got %b want 0", bus.pmem_read); end
        if (bus.pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write: got %b want 0", bus.pmem_write); end
        if (bus.pmem_address !== '0) begin failures++; $display("FAIL reset_pmem_address: got %h want 0", bus.pmem_address); end
        if (bus.pmem_wdata !== '0) begin failures++; $display("FAIL reset_pmem_wdata: got %h want 0", bus.pmem_wdata); end
        if (bus.i_resp !== 1'b0) begin failures++; $display("FAIL reset_i_resp: got %b want 0", bus.i_resp); end
        if (bus.d_resp !== 1'b0) begin failures++; $display("FAIL reset_d_resp: got %b want 0", bus.d_resp); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        int rd_cyc = 0, wr_cyc = 0, iresp = 0, dresp = 0;
        bit addr_bad = 0, data_bad = 0;
        logic [LW-1:0] exp_data = {32{8'hA5}};
        mem[32'h1000] = exp_data;
        set_lat(2);
        bus.i_address = 32'h1000;
        bus.i_read = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.pmem_read) begin
                rd_cyc++;
                if (bus.pmem_address !== 32'h1000) addr_bad = 1;
            end
            if (bus.pmem_write) wr_cyc++;
            if (bus.d_resp) dresp++;
            if (bus.i_resp) begin
                iresp++;
                if (bus.i_rdata !== exp_data) data_bad = 1;
                bus.i_read = 1'b0;
            end
        end
        checks += 6;
        if (rd_cyc !== 3) begin failures++; $display("FAIL iread_strobe_cycles: got %0d want 3", rd_cyc); end
        if (wr_cyc !== 0) begin failures++; $display("FAIL iread_no_write: got %0d want 0", wr_cyc); end
        if (addr_bad) begin failures++; $display("FAIL iread_address: got bad want 00001000"); end
        if (iresp !== 1) begin failures++; $display("FAIL iread_resp_count: got %0d want 1", iresp); end
        if (data_bad) begin failures++; $display("FAIL iread_rdata: got bad want a5..a5"); end
        if (dresp !== 0) begin failures++; $display("FAIL iread_d_resp: got %0d want 0", dresp); end
    endtask

    task automatic test_d_write();
        int wr_cyc = 0, dresp = 0, iresp = 0, resp_at = -1, rd_at = -1;
        bit bad = 0;
        logic [LW-1:0] wd = {8{32'h1234_5678}};
        set_lat(0);
        bus.d_address = 32'h2040;
        bus.d_wdata = wd;
        bus.d_write = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.pmem_write) begin
                wr_cyc++;
                if (bus.pmem_address !== 32'h2040 || bus.pmem_wdata !== wd) bad = 1;
            end
            if (bus.pmem_read && rd_at < 0) rd_at = c;
            if (bus.i_resp) begin
                iresp++;
                bus.i_read = 1'b0;
            end
            if (bus.d_resp) begin
                dresp++;
                resp_at = c;
                bus.d_write = 1'b0;
                bus.i_address = 32'h5000;
                bus.i_read = 1'b1;
            end
        end
        checks += 6;
        if (wr_cyc !== 1) begin failures++; $display("FAIL dwrite_strobe_cycles: got %0d want 1", wr_cyc); end
        if (bad) begin failures++; $display("FAIL dwrite_addr_data: got bad want 00002040/1234..."); end
        if (dresp !== 1) begin failures++; $display("FAIL dwrite_resp_count: got %0d want 1", dresp); end
        if (mem[32'h2040] !== wd) begin failures++; $display("FAIL dwrite_mem: got %h want %h", mem[32'h2040], wd); end
        if (rd_at !== resp_at + 3) begin failures++; $display("FAIL dwrite_gap: got next strobe at %0d want %0d", rd_at, resp_at + 3); end
        if (iresp !== 1) begin failures++; $display("FAIL dwrite_follow_iresp: got %0d want 1", iresp); end
    endtask

    task automatic test_tie();
        logic [AW-1:0] seq[$];
        int d_done = -1, i_start = -1, iresp = 0, dresp = 0;
        bit prev_strobe = 0;
        bit strobe;
        do_reset();
        set_lat(1);
        bus.i_address = 32'h1100;
        bus.d_address = 32'h2200;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            strobe = bus.pmem_read || bus.pmem_write;
            if (strobe && !prev_strobe) begin
                seq.push_back(bus.pmem_address);
                if (seq.size() == 2) i_start = c;
            end
            prev_strobe = strobe;
            if (bus.d_resp) begin dresp++; d_done = c; bus.d_read = 1'b0; end
            if (bus.i_resp) begin iresp++; bus.i_read = 1'b0; end
        end
        checks += 4;
        if (seq.size() != 2) begin
            failures++;
            $display("FAIL tie_txn_count: got %0d want 2", seq.size());
        end else begin
            checks += 2;
            if (seq[0] !== 32'h2200) begin failures++; $display("FAIL tie_first_addr: got %h want 00002200", seq[0]); end
            if (seq[1] !== 32'h1100) begin failures++; $display("FAIL tie_second_addr: got %h want 00001100", seq[1]); end
        end
        if (i_start !== d_done + 3) begin failures++; $display("FAIL tie_i_grant_time: got %0d want %0d", i_start, d_done + 3); end
        if (dresp !== 1) begin failures++; $display("FAIL tie_d_resp: got %0d want 1", dresp); end
        if (iresp !== 1) begin failures++; $display("FAIL tie_i_resp: got %0d want 1", iresp); end
    endtask

    task automatic test_alternate();
        int n_done = 0;
        bit exp_d = 1;
        logic [LW-1:0] exp_data;
        do_reset();
        rand_lat = 1;
        lat = int'($urandom_range(0, 3));
        bus.i_address = 32'h4000;
        bus.d_address = 32'h6000;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int c = 0; c < 80 && n_done < 6; c++) begin
            tick();
            if (bus.i_resp || bus.d_resp) begin
                checks += 2;
                if ({bus.d_resp, bus.i_resp} !== (exp_d ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL alt_grant_%0d: got d/i resp %b%b want %s", n_done, bus.d_resp, bus.i_resp, exp_d ? "D" : "I");
                end
                exp_data = mem_rd(exp_d ? bus.d_address : bus.i_address);
                if ((exp_d ? bus.d_rdata : bus.i_rdata) !== exp_data) begin
                    failures++;
                    $display("FAIL alt_rdata_%0d: got %h want %h", n_done, exp_d ? bus.d_rdata : bus.i_rdata, exp_data);
                end
                if (bus.d_resp) bus.d_address = bus.d_address + 32'd32;
                if (bus.i_resp) bus.i_address = bus.i_address + 32'd32;
                exp_d = !exp_d;
                n_done++;
                if (n_done == 6) begin
                    bus.i_read = 1'b0;
                    bus.d_read = 1'b0;
                end
            end
        end
        checks++;
        if (n_done !== 6) begin failures++; $display("FAIL alt_done: got %0d want 6", n_done); end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int iresp = 0;
        set_lat(3);
        bus.i_address = 32'h1000;
        bus.i_read = 1'b1;
        tick();
        if (bus.i_resp) iresp++;
        tick();
        if (bus.i_resp) iresp++;
        checks++;
        if (bus.pmem_read !== 1'b1) begin failures++; $display("FAIL rstmid_pre_strobe: got %b want 1", bus.pmem_read); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL rstmid_strobe_drop: got %b want 0", bus.pmem_read); end
        tick();
        if (bus.i_resp) iresp++;
        checks++;
        if (iresp !== 0) begin failures++; $display("FAIL rstmid_no_resp: got %0d want 0", iresp); end
        rst_n = 1'b1;
        set_lat(1);
        tick();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h1000) begin
            failures++;
            $display("FAIL rstmid_regrant: got read=%b addr=%h want 1/00001000", bus.pmem_read, bus.pmem_address);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.i_resp) begin iresp++; bus.i_read = 1'b0; end
        end
        checks++;
        if (iresp !== 1) begin failures++; $display("FAIL rstmid_resp_after: got %0d want 1", iresp); end
    endtask

    task automatic test_addr_change();
        int strobes = 0, iresp = 0;
        bit bad = 0, data_bad = 0;
        set_lat(3);
        bus.i_address = 32'h1000;
        bus.i_read = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.pmem_read) begin
                strobes++;
                if (bus.pmem_address !== 32'h1000) bad = 1;
                bus.i_address = 32'h3000;
            end
            if (bus.i_resp) begin
                iresp++;
                if (bus.i_rdata !== {32{8'hA5}}) data_bad = 1;
                bus.i_read = 1'b0;
            end
        end
        checks += 4;
        if (strobes !== 4) begin failures++; $display("FAIL addrchg_strobes: got %0d want 4", strobes); end
        if (bad) begin failures++; $display("FAIL addrchg_address: got changed want 00001000"); end
        if (iresp !== 1) begin failures++; $display("FAIL addrchg_resp: got %0d want 1", iresp); end
        if (data_bad) begin failures++; $display("FAIL addrchg_rdata: got bad want a5..a5"); end
    endtask

    task automatic test_random();
        logic [LW-1:0] ref_mem [logic [AW-1:0]];
        logic [LW-1:0] exp_data, got_data;
        logic [AW-1:0] exp_addr;
        bit last_d = 0, cur_d = 0, exp_wr, prev_strobe = 0, strobe;
        bit i_lvl = 0, d_lvl = 0, i_just, d_just;
        int done = 0, cyc = 0;
        do_reset();
        rand_lat = 1;
        lat = int'($urandom_range(0, 3));
        while (done < 40 && cyc < 3000) begin
            tick();
            cyc++;
            i_just = 0;
            d_just = 0;
            strobe = bus.pmem_read || bus.pmem_write;
            if (strobe && !prev_strobe) begin
                checks++;
                if (!(i_lvl || d_lvl)) begin
                    failures++;
                    $display("FAIL rand_spurious_grant: got strobe want none at cycle %0d", cyc);
                end
                cur_d  = (i_lvl && d_lvl) ? !last_d : d_lvl;
                last_d = cur_d;
            end
            if (strobe) begin
                exp_addr = cur_d ? bus.d_address : bus.i_address;
                exp_wr   = cur_d && bus.d_write;
                checks++;
                if (bus.pmem_address !== exp_addr || bus.pmem_write !== exp_wr || bus.pmem_read !== !exp_wr
                    || (exp_wr && bus.pmem_wdata !== bus.d_wdata)) begin
                    failures++;
                    $display("FAIL rand_pmem_req: got addr=%h w=%b want addr=%h w=%b port=%s", bus.pmem_address, bus.pmem_write, exp_addr, exp_wr, cur_d ? "D" : "I");
                end
            end
            if (bus.i_resp || bus.d_resp) begin
                checks++;
                if ({bus.d_resp, bus.i_resp} !== (cur_d ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL rand_resp_port: got d/i %b%b want %s", bus.d_resp, bus.i_resp, cur_d ? "D" : "I");
                end
                exp_addr = cur_d ? bus.d_address : bus.i_address;
                if (cur_d && bus.d_write) begin
                    ref_mem[exp_addr] = bus.d_wdata;
                end else begin
                    exp_data = ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : init_line(exp_addr);
                    got_data = cur_d ? bus.d_rdata : bus.i_rdata;
                    checks++;
                    if (got_data !== exp_data) begin
                        failures++;
                        $display("FAIL rand_rdata: got %h want %h addr=%h", got_data, exp_data, exp_addr);
                    end
                end
                if (cur_d) begin
                    bus.d_read = 1'b0;
                    bus.d_write = 1'b0;
                    d_just = 1;
                end else begin
                    bus.i_read = 1'b0;
                    i_just = 1;
                end
                done++;
            end
            prev_strobe = strobe;
            if (!bus.i_read && !i_just && $urandom_range(0, 1) == 1) begin
                bus.i_address = 32'h8000_0000 + 32 * $urandom_range(0, 7);
                bus.i_read = 1'b1;
            end
            if (!bus.d_read && !bus.d_write && !d_just && $urandom_range(0, 1) == 1) begin
                bus.d_address = 32'h8000_0000 + 32 * $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < 8; k++) bus.d_wdata[k*32 +: 32] = $urandom();
                    bus.d_write = 1'b1;
                end else begin
                    bus.d_read = 1'b1;
                end
            end
            i_lvl = bus.i_read;
            d_lvl = bus.d_read || bus.d_write;
        end
        checks++;
        if (done < 40) begin failures++; $display("FAIL rand_progress: got %0d want 40 completions", done); end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_read = 1'b0;
        bus.i_address = '0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_address = '0;
        bus.d_wdata = '0;
        test_reset();
        test_i_read();
        test_d_write();
        test_tie();
        test_alternate();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
